// File: rtl/dijkstra_edge_feeder_pkg.sv
// ---------------------------------------------------------------------------
// dijkstra_pkg
// Shared definitions for the Dijkstra edge feeder: FSM state encoding,
// the fixed word stride, default parameter values and a small helper that
// word-aligns a byte address.
// ---------------------------------------------------------------------------
package dijkstra_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int WORD_BYTES     = 4;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CNT_W      = 16;

  // Forces the two byte-offset bits to zero so every read is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dijkstra_edge_feeder_if.sv
// ---------------------------------------------------------------------------
// dijkstra_edge_feeder_if
// Bundles the three buses the feeder talks on:
//   - Nios II custom instruction : clk_en, start, dataa, datab, done, result
//   - Avalon-MM read master      : rd_address, rd_read, rd_readdata,
//                                  rd_readdatavalid, rd_waitrequest
//   - Avalon-MM write master     : wr_write, wr_writedata, wr_waitrequest
// Modports:
//   master - the feeder's view (drives requests, done/result)
//   slave  - the environment's view (CPU, memory and accelerator slave)
// ---------------------------------------------------------------------------
interface dijkstra_edge_feeder_if
  import dijkstra_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              clk_en;
  logic              start;
  logic [31:0]       dataa;
  logic [31:0]       datab;
  logic              done;
  logic [31:0]       result;

  logic [ADDR_W-1:0] rd_address;
  logic              rd_read;
  logic [DATA_W-1:0] rd_readdata;
  logic              rd_readdatavalid;
  logic              rd_waitrequest;

  logic              wr_write;
  logic [DATA_W-1:0] wr_writedata;
  logic              wr_waitrequest;

  modport master (
    input  clk_en, start, dataa, datab,
    input  rd_readdata, rd_readdatavalid, rd_waitrequest,
    input  wr_waitrequest,
    output done, result,
    output rd_address, rd_read,
    output wr_write, wr_writedata
  );

  modport slave (
    output clk_en, start, dataa, datab,
    output rd_readdata, rd_readdatavalid, rd_waitrequest,
    output wr_waitrequest,
    input  done, result,
    input  rd_address, rd_read,
    input  wr_write, wr_writedata
  );

endinterface

// File: rtl/dijkstra_edge_feeder_fifo.sv
// ---------------------------------------------------------------------------
// feeder_fifo
// Synchronous FIFO buffering read data between the read and write masters.
// Simultaneous push and pop are accepted in every state, including full
// (the pop frees the slot being written) and empty (the pop is dropped).
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   i_push        write i_data at the tail
//   i_pop         discard the head word
//   i_data        data to push
//   o_data        current head word (undefined content while empty)
//   o_used        number of stored words, 0..DEPTH
//   o_empty       no words stored
//   o_full        DEPTH words stored
// ---------------------------------------------------------------------------
module feeder_fifo
  import dijkstra_pkg::*;
#(
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [DATA_W-1:0]          i_data,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(DEPTH):0]     o_used,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_used;

  logic              w_do_pop;
  logic              w_do_push;

  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is only safe when the head leaves this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_used <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_used  = r_used;
  assign o_empty = (r_used == '0);
  assign o_full  = (r_used == (AW+1)'(DEPTH));

endmodule

// File: rtl/dijkstra_edge_feeder.sv
// ---------------------------------------------------------------------------
// dijkstra_edge_feeder
// Streams edge-weight words from system memory into the Dijkstra
// accelerator. The Nios II launches a job through a custom instruction
// (dataa = byte base address, datab = word count); the block issues
// pipelined single-word Avalon reads, buffers the returned data and
// replays every word, in address order, as an Avalon write to the
// accelerator slave. done pulses for one cycle at the end of the job and
// result reports how many words were written.
// Ports:
//   clk       single clock
//   reset_n   asynchronous active-low reset
//   bus       dijkstra_edge_feeder_if.master (custom instruction, read
//             master and write master signals)
// ---------------------------------------------------------------------------
module dijkstra_edge_feeder
  import dijkstra_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dijkstra_edge_feeder_if.master bus
);

  localparam int FAW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_FIN  = FIN;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_pending;
  logic [CNT_W-1:0]  r_written;
  logic [31:0]       r_result;

  logic              w_launch;
  logic [31:0]       w_base_addr;
  logic [CNT_W-1:0]  w_start_count;
  logic [CNT_W:0]    w_inflight;
  logic              w_rd_read;
  logic              w_rd_acc;
  logic              w_ret;
  logic              w_wr_write;
  logic              w_wr_acc;
  logic              w_last_write;
  logic [DATA_W-1:0] w_fifo_data;
  logic [FAW:0]      w_fifo_used;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_unused;

  assign w_launch      = (r_state == S_IDLE) && bus.clk_en && bus.start;
  assign w_base_addr   = align_word(bus.dataa);
  assign w_start_count = bus.datab[CNT_W-1:0];

  // Upper datab bits are dropped by design; full is implied by the credit
  // check below and never needed directly.
  assign w_unused = ^{w_fifo_full, bus.datab};

  // Credit: every outstanding read already owns a FIFO slot, so a new read
  // is only issued when buffered plus outstanding words leave room. The
  // terms can only shrink while a read is stalled, which keeps rd_read
  // stable under rd_waitrequest.
  assign w_inflight = {1'b0, r_pending} + (CNT_W+1)'(w_fifo_used);

  assign w_rd_read  = (r_state == S_RUN) && (r_issued < r_count) &&
                      (w_inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign w_rd_acc   = w_rd_read && !bus.rd_waitrequest;

  // Returns outside a job, or with nothing outstanding, are stray and dropped.
  assign w_ret      = (r_state == S_RUN) && bus.rd_readdatavalid &&
                      (r_pending != '0);

  assign w_wr_write   = (r_state == S_RUN) && !w_fifo_empty;
  assign w_wr_acc     = w_wr_write && !bus.wr_waitrequest;
  assign w_last_write = w_wr_acc && ((r_written + 1'b1) == r_count);

  feeder_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_ret),
    .i_pop   (w_wr_acc),
    .i_data  (bus.rd_readdata),
    .o_data  (w_fifo_data),
    .o_used  (w_fifo_used),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_count   <= '0;
      r_issued  <= '0;
      r_pending <= '0;
      r_written <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_addr    <= ADDR_W'(w_base_addr);
            r_count   <= w_start_count;
            r_issued  <= '0;
            r_pending <= '0;
            r_written <= '0;
            if (w_start_count == '0) begin
              r_result <= '0;
              r_state  <= S_FIN;
            end else begin
              r_state  <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (w_rd_acc) begin
            r_issued <= r_issued + 1'b1;
            r_addr   <= r_addr + ADDR_W'(WORD_BYTES);
          end
          case ({w_rd_acc, w_ret})
            2'b10:   r_pending <= r_pending + 1'b1;
            2'b01:   r_pending <= r_pending - 1'b1;
            default: r_pending <= r_pending;
          endcase
          if (w_wr_acc) begin
            r_written <= r_written + 1'b1;
          end
          // result is loaded on entry so it is already valid while done is high.
          if (w_last_write) begin
            r_result <= 32'(r_written + 1'b1);
            r_state  <= S_FIN;
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.done         = (r_state == S_FIN);
  assign bus.result       = r_result;
  assign bus.rd_address   = r_addr;
  assign bus.rd_read      = w_rd_read;
  assign bus.wr_write     = w_wr_write;
  // FIFO storage is not reset, so the head is masked to zero while empty.
  assign bus.wr_writedata = w_fifo_empty ? '0 : w_fifo_data;

endmodule

// File: tb/tb_dijkstra_edge_feeder.sv
// ---------------------------------------------------------------------------
// tb_dijkstra_edge_feeder
// Drives jobs through the custom-instruction port, models the read slave
// (configurable latency and waitrequest pattern) and the accelerator write
// slave (programmable stall window), and scoreboards every written word.
// ---------------------------------------------------------------------------
module tb_dijkstra_edge_feeder;
  import dijkstra_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  dijkstra_edge_feeder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dijkstra_edge_feeder #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          stray;
  } resp_t;

  int          total = 0;
  int          bad = 0;
  int          cycle = 0;

  resp_t       respQ[$];
  logic [31:0] expQ[$];
  logic [31:0] expRdAddr = 32'h0;

  int          rdLatency = 1;
  int          rdWaitMode = 0;
  int          wrStallFrom = -1;
  int          wrStallLen = 0;

  int          outstanding = 0;
  int          fifoCnt = 0;
  int          maxInflight = 0;
  int          maxFifo = 0;
  int          rdSeen = 0;
  int          wrSeen = 0;
  int          lastWrCycle = -1;

  bit          prevRdStall = 1'b0;
  bit          prevWrStall = 1'b0;
  logic [31:0] prevRdAddr = 32'h0;
  logic [31:0] prevWrData = 32'h0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Memory image: the first four words at 0x1000 hold 1..4, elsewhere an
  // address-derived pattern.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a >= 32'h1000 && a < 32'h1010) begin
      return ((a - 32'h1000) >> 2) + 32'd1;
    end
    return {a[15:0] ^ 16'h5A5A, a[31:16] + a[15:0]};
  endfunction

  // Read slave, write slave and bus-rule monitor, one step per cycle.
  initial begin
    resp_t r;
    bus.rd_readdatavalid = 1'b0;
    bus.rd_readdata      = 32'h0;
    bus.rd_waitrequest   = 1'b0;
    bus.wr_waitrequest   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        foreach (respQ[i]) respQ[i].stray = 1'b1;
        outstanding = 0;
        fifoCnt     = 0;
        prevRdStall = 1'b0;
        prevWrStall = 1'b0;
      end

      if (reset_n && prevRdStall) begin
        checkOutput("rd_hold_read", bus.rd_read, 1);
        checkOutput("rd_hold_addr", bus.rd_address, prevRdAddr);
      end
      if (reset_n && prevWrStall) begin
        checkOutput("wr_hold_write", bus.wr_write, 1);
        checkOutput("wr_hold_data", bus.wr_writedata, prevWrData);
      end
      if (reset_n && (outstanding + fifoCnt >= DEPTH)) begin
        checkOutput("credit_block", bus.rd_read, 0);
      end
      if (reset_n && bus.rd_read) rdSeen++;
      if (reset_n && bus.wr_write) wrSeen++;

      bus.rd_readdatavalid = 1'b0;
      bus.rd_readdata      = $urandom;
      if (respQ.size() > 0 && respQ[0].due <= cycle) begin
        r = respQ.pop_front();
        bus.rd_readdatavalid = 1'b1;
        bus.rd_readdata      = r.data;
        if (!r.stray) begin
          outstanding--;
          fifoCnt++;
        end
      end

      case (rdWaitMode)
        0:       bus.rd_waitrequest = 1'b0;
        1:       bus.rd_waitrequest = cycle[0];
        default: bus.rd_waitrequest = 1'($urandom_range(0, 1));
      endcase
      bus.wr_waitrequest = (wrStallFrom >= 0) && (cycle >= wrStallFrom) &&
                           (cycle < wrStallFrom + wrStallLen);

      if (reset_n && bus.rd_read && !bus.rd_waitrequest) begin
        checkOutput("rd_addr", bus.rd_address, expRdAddr);
        expRdAddr = expRdAddr + 32'd4;
        respQ.push_back('{cycle + rdLatency, memWord(bus.rd_address), 1'b0});
        outstanding++;
      end
      if (reset_n && bus.wr_write && !bus.wr_waitrequest) begin
        if (expQ.size() == 0) checkOutput("extra_write", 1, 0);
        else checkOutput("wr_data", bus.wr_writedata, expQ.pop_front());
        fifoCnt--;
        lastWrCycle = cycle;
      end

      prevRdStall = reset_n && bus.rd_read && bus.rd_waitrequest;
      prevRdAddr  = bus.rd_address;
      prevWrStall = reset_n && bus.wr_write && bus.wr_waitrequest;
      prevWrData  = bus.wr_writedata;
      if (outstanding + fifoCnt > maxInflight) maxInflight = outstanding + fifoCnt;
      if (fifoCnt > maxFifo) maxFifo = fifoCnt;
    end
  end

  // Launches one job, scoreboards its words and waits for done.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] n,
                               input int pokeAt, input int expFirstWr,
                               output int doneK);
    int cnt;
    int c0;
    int firstWr;
    int extraDone;
    cnt = int'(n[15:0]);
    expQ.delete();
    for (int i = 0; i < cnt; i++) begin
      expQ.push_back(memWord((a & 32'hFFFF_FFFC) + 32'(i * 4)));
    end
    expRdAddr   = a & 32'hFFFF_FFFC;
    rdSeen      = 0;
    wrSeen      = 0;
    maxInflight = 0;
    maxFifo     = 0;
    firstWr     = -1;
    extraDone   = 0;
    doneK       = -1;

    @(negedge clk);
    bus.start  = 1'b1;
    bus.clk_en = 1'b1;
    bus.dataa  = a;
    bus.datab  = n;
    c0 = cycle;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      bus.start  = (k == pokeAt);
      bus.clk_en = (k == pokeAt);
      if (k == pokeAt) begin
        bus.dataa = 32'h9000;
        bus.datab = 32'd5;
      end
      if (bus.wr_write && firstWr < 0) firstWr = k;
      if (bus.done) begin
        doneK = k;
        break;
      end
    end
    bus.start  = 1'b0;
    bus.clk_en = 1'b0;

    if (doneK < 0) begin
      checkOutput("done_timeout", 0, 1);
    end else begin
      checkOutput("result", bus.result, 64'(cnt));
      checkOutput("leftover", expQ.size(), 0);
      if (cnt > 0) checkOutput("done_latency", c0 + doneK, lastWrCycle + 1);
      if (expFirstWr > 0) checkOutput("first_write", firstWr, expFirstWr);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (bus.done) extraDone++;
    end
    checkOutput("done_once", extraDone, 0);
  endtask

  initial begin
    int dk;
    int doneSeen;
    bus.start  = 1'b0;
    bus.clk_en = 1'b0;
    bus.dataa  = 32'h0;
    bus.datab  = 32'h0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_rd_read", bus.rd_read, 0);
    checkOutput("rst_wr_write", bus.wr_write, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_result", bus.result, 0);
    checkOutput("rst_rd_address", bus.rd_address, 0);
    checkOutput("rst_wr_writedata", bus.wr_writedata, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] start without clk_en");
    rdSeen     = 0;
    bus.start  = 1'b1;
    bus.clk_en = 1'b0;
    bus.datab  = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    doneSeen  = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (bus.done) doneSeen++;
    end
    checkOutput("clken_gate_rd", rdSeen, 0);
    checkOutput("clken_gate_done", doneSeen, 0);

    $display("[TB] basic 4-word job");
    applyStimulus(32'h1000, 32'd4, 0, 3, dk);

    $display("[TB] zero-length job");
    applyStimulus(32'h3000, 32'd0, 0, 0, dk);
    checkOutput("zero_done_by2", (dk >= 1 && dk <= 2), 1);
    checkOutput("zero_no_read", rdSeen, 0);
    checkOutput("zero_no_write", wrSeen, 0);

    $display("[TB] 20 words, read latency 5");
    rdLatency = 5;
    applyStimulus(32'h4000, 32'd20, 0, 0, dk);
    checkOutput("credit_max", (maxInflight <= DEPTH), 1);

    $display("[TB] write stall, 12 words");
    rdLatency   = 1;
    wrStallFrom = cycle + 7;
    wrStallLen  = 10;
    applyStimulus(32'h5000, 32'd12, 0, 0, dk);
    checkOutput("fifo_filled", maxFifo, DEPTH);
    checkOutput("stall_credit_max", (maxInflight <= DEPTH), 1);
    wrStallFrom = -1;

    $display("[TB] unaligned base, read waitrequest");
    rdWaitMode = 1;
    applyStimulus(32'h2003, 32'd6, 0, 0, dk);
    rdWaitMode = 2;
    applyStimulus(32'h2100, 32'd10, 0, 0, dk);
    rdWaitMode = 0;

    $display("[TB] start mid-job");
    applyStimulus(32'h6000, 32'd8, 4, 0, dk);

    $display("[TB] reset mid-job");
    rdLatency = 3;
    expQ.delete();
    for (int i = 0; i < 16; i++) expQ.push_back(memWord(32'h7000 + 32'(i * 4)));
    expRdAddr = 32'h7000;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.clk_en = 1'b1;
    bus.dataa  = 32'h7000;
    bus.datab  = 32'd16;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.clk_en = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_rd_read", bus.rd_read, 0);
    checkOutput("abort_wr_write", bus.wr_write, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_rd_address", bus.rd_address, 0);
    checkOutput("abort_wr_writedata", bus.wr_writedata, 0);
    checkOutput("abort_result", bus.result, 0);
    repeat (3) @(negedge clk);
    reset_n  = 1'b1;
    rdSeen   = 0;
    doneSeen = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (bus.done) doneSeen++;
    end
    checkOutput("abort_no_done", doneSeen, 0);
    checkOutput("abort_no_read", rdSeen, 0);
    expQ.delete();
    rdLatency = 1;
    applyStimulus(32'h1000, 32'd4, 0, 3, dk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/dijkstra_edge_feeder.md
Name: dijkstra_edge_feeder

Overview:
- Avalon-MM initiator that streams edge-weight words from system memory into the Dijkstra accelerator's write slave.
- The Nios II side launches it through a custom-instruction interface: dataa = byte base address, datab = word count.
- Issues pipelined bursts of single-word reads, buffers the returned data in a small FIFO, and replays each word as an Avalon write to the accelerator.
- Signals completion with done/result.

Parameters:
ADDR_W, 32, read-master byte address width
DATA_W, 32, data word width (word stride fixed at 4 bytes)
FIFO_DEPTH, 8, buffer depth and maximum reads in flight (power of 2, >=2)
CNT_W, 16, width of the internal word counters (count is truncated to CNT_W bits)

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous, active-low reset
clk_en  in  1  custom-instruction clock enable; start is sampled only when high
start  in  1  custom-instruction start
dataa  in  32  base byte address (bits [1:0] forced to 0)
datab  in  32  word count
done  out  1  one-cycle completion pulse
result  out  32  words written in the last completed job
rd_address  out  ADDR_W  read-master address
rd_read  out  1  read request
rd_readdata  in  DATA_W  read data
rd_readdatavalid  in  1  read data valid
rd_waitrequest  in  1  read-slave stall
wr_write  out  1  write request to the accelerator slave
wr_writedata  out  DATA_W  write data
wr_waitrequest  in  1  accelerator-slave stall

Behaviour:
- Reset (async assert, sync release): state IDLE; done=0, result=0, rd_read=0, wr_write=0, rd_address=0, wr_writedata=0; all counters 0; FIFO empty.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE:
  - On clk_en && start, latch addr = {dataa[31:2],2'b00}, count = datab[CNT_W-1:0]; clear issued, pending, written.
  - Go to RUN, or to FIN directly if count==0.
- RUN, read side:
  - rd_read=1 when issued<count and (fifo_used+pending)<FIFO_DEPTH.
  - rd_address and rd_read are held stable while rd_waitrequest=1.
  - Acceptance is rd_read && !rd_waitrequest: issued+1, pending+1, address+4 (wraps modulo 2^ADDR_W).
- RUN, return side:
  - rd_readdatavalid pushes rd_readdata into the FIFO and decrements pending.
  - Acceptance and return in the same cycle leave pending unchanged.
  - Credit rule guarantees no overflow. A readdatavalid with pending==0 is ignored.
- RUN, write side:
  - wr_write=1 whenever the FIFO is non-empty; wr_writedata = FIFO head.
  - Both are held stable while wr_waitrequest=1.
  - Acceptance is wr_write && !wr_waitrequest: pop, written+1.
  - Push and pop in the same cycle are legal, including at full and at empty.
- Transition to FIN when written==count after an acceptance.
- FIN (exactly one cycle): done=1, result=written zero-extended; then IDLE.
- result holds its value until the next FIN.
- Ordering: words are written in address order.
- Minimum latency with zero wait states and readdatavalid one cycle after acceptance: first wr_write in the 3rd cycle after start; done in the cycle after the last write acceptance.
- start while not IDLE is ignored. clk_en low does not stall a running job.
- Reset asserted mid-job: immediate abort; FIFO cleared; no done pulse. Late readdatavalid arriving after reset release is ignored (state IDLE).

Decomposition:
- Package dijkstra_pkg: state enum (IDLE, RUN, FIN), WORD_BYTES=4 constant, default parameter values.
- Sub-module feeder_fifo: synchronous FIFO with push, pop, data_in, data_out, used, empty, full, and the same async active-low reset.
- FSM, counters and both master interfaces live in the top module.

Test Plan:
- dataa=0x1000, datab=4, mem[0x1000..0x100C]=1,2,3,4, no wait states -> writes 1,2,3,4 in order; done pulses once; result=4.
- datab=0 -> no rd_read or wr_write; done in the 2nd cycle after start; result=0.
- datab=20, read latency 5 cycles, FIFO_DEPTH=8 -> pending+fifo_used never exceeds 8; 20 writes in address order; result=20.
- wr_waitrequest=1 for 10 cycles mid-job, datab=12 -> wr_writedata stable while stalled; FIFO fills to 8 and rd_read drops; all 12 words delivered; no loss or duplication.
- dataa=0x2003 -> first rd_address=0x2000. rd_waitrequest toggling -> address and read held stable each stalled cycle.
- start pulsed again mid-job ignored; later reset_n low mid-job -> outputs 0 at once; no done; a fresh job after reset release completes correctly.
